periph_timer_bank: RTL and testbench

- Memory-mapped peripheral hub for the single-cycle MIPS CPU, decoded on the data-memory bus at BASE_ADDR.
- Provides NUM_TIMERS reloadable up-counting timers with per-channel interrupt status (write-1-to-clear), an LED register and a synchronised switch input.
- Includes a hardware-scanned hex 7-segment display, so software no longer drives digit multiplexing from a timer ISR.
- Drives a single OR-combined interrupt request to the CPU.

---
 rtl/periph_pkg.sv | 34 +++
 rtl/periph_timer_bank_if.sv | 12 +
 rtl/periph_timer_ch.sv | 48 ++++
 rtl/periph_timer_bank.sv | 153 +++++++++++++++
 tb/tb_periph_timer_bank.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/periph_pkg.sv
// Shared constants for the peripheral hub: register offsets, timer layout, TCON bits, hex font.
// Pure declarations; carries no timing or flow control of its own.
package periph_pkg;

    localparam logic [31:0] OFF_LED      = 32'h00;
    localparam logic [31:0] OFF_SWITCH   = 32'h04;
    localparam logic [31:0] OFF_SEGDATA  = 32'h08;
    localparam logic [31:0] OFF_SEGCTRL  = 32'h0C;
    localparam logic [31:0] OFF_IRQSTAT  = 32'h10;
    localparam logic [31:0] OFF_SWCHG    = 32'h14;
    localparam logic [31:0] OFF_SWMASK   = 32'h18;
    localparam logic [31:0] OFF_TMR_BASE = 32'h20;
    localparam logic [31:0] TMR_STRIDE   = 32'h10;
    localparam logic [31:0] OFF_TH       = 32'h00;
    localparam logic [31:0] OFF_TL       = 32'h04;
    localparam logic [31:0] OFF_TCON     = 32'h08;

    localparam int TCON_EN   = 0;
    localparam int TCON_IE   = 1;
    localparam int TCON_PEND = 2;

    // Active-high segments {g..a}, indexed by hex nibble.
    localparam logic [15:0][6:0] HEX7 = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [31:0] tmr_addr(input logic [31:0] base,
                                             input int unsigned k,
                                             input logic [31:0] off);
        return base + OFF_TMR_BASE + TMR_STRIDE * k + off;
    endfunction

endpackage

// File: rtl/periph_timer_bank_if.sv
// CPU data-memory bus into the peripheral hub; rdata is combinational, same cycle as mem_rd.
// No backpressure: every access completes in the cycle it is presented.
interface periph_timer_bank_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_rd;
    logic        mem_wr;

    modport master (output addr, output wdata, output mem_rd, output mem_wr, input rdata);
    modport slave  (input addr, input wdata, input mem_rd, input mem_wr, output rdata);
endinterface

// File: rtl/periph_timer_ch.sv
// One reloadable up-counter: TH/TL/TCON plus a W1C pending flag; writes land on the strobe edge.
// No backpressure; a TL write beats count/reload, and a set beats a same-cycle clear.
module periph_timer_ch
    import periph_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               th_wr,
    input  logic               tl_wr,
    input  logic               tcon_wr,
    input  logic               pend_clr,
    input  logic [TIMER_W-1:0] wval,
    output logic [TIMER_W-1:0] th,
    output logic [TIMER_W-1:0] tl,
    output logic               en,
    output logic               ie,
    output logic               pending
);

    localparam logic [TIMER_W-1:0] RST_VAL = {TIMER_W{1'b1}} << 11;

    logic wrap;
    assign wrap = en && (&tl);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th      <= RST_VAL;
            tl      <= RST_VAL;
            en      <= 1'b0;
            ie      <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (th_wr) th <= wval;
            // Reload samples th before this edge, so a racing TH write only affects the next wrap.
            if (tl_wr)   tl <= wval;
            else if (en) tl <= wrap ? th : tl + TIMER_W'(1);
            if (tcon_wr) begin
                en <= wval[TCON_EN];
                ie <= wval[TCON_IE];
            end
            if (wrap && ie)    pending <= 1'b1;
            else if (pend_clr) pending <= 1'b0;
        end
    end

endmodule

// File: rtl/periph_timer_bank.sv
// MMIO hub: timers, LEDs, synchronised switches, scanned 7-seg; reads combinational, writes on edge.
// No backpressure. Optional SWITCH_CHANGE_IRQ_EN adds switch-change status/mask at 0x14/0x18.
module periph_timer_bank
    import periph_pkg::*;
#(
    parameter int          NUM_TIMERS = 2,
    parameter int          TIMER_W    = 32,
    parameter int          LED_W      = 8,
    parameter int          SW_W       = 8,
    parameter int          NUM_DIGITS = 4,
    parameter int          SCAN_DIV_W = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    periph_timer_bank_if.slave    bus,
    output logic [LED_W-1:0]      led,
    input  logic [SW_W-1:0]       sw,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg,
    output logic [NUM_TIMERS-1:0] timer_irq,
    output logic                  irq
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [63:0] NIB_MASK = (64'd1 << (4 * NUM_DIGITS)) - 64'd1;
    localparam logic [31:0] SEG_MASK = 32'hFF00_0000 | NIB_MASK[31:0];
    localparam logic [NUM_DIGITS-1:0] DIG_ONE = 1;

    logic [TIMER_W-1:0]    th [NUM_TIMERS];
    logic [TIMER_W-1:0]    tl [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] en, ie, pending;

    logic [LED_W-1:0]      led_q;
    logic [SW_W-1:0]       sw_s1, sw_s2;
    logic [31:0]           segdata;
    logic                  scan_en;
    logic [SCAN_DIV_W-1:0] presc;
    logic [IDX_W-1:0]      idx;
    logic [31:0]           rd_c;

    logic wr_led, wr_segdata, wr_segctrl, wr_irqstat;
    assign wr_led     = bus.mem_wr && (bus.addr == BASE_ADDR + OFF_LED);
    assign wr_segdata = bus.mem_wr && (bus.addr == BASE_ADDR + OFF_SEGDATA);
    assign wr_segctrl = bus.mem_wr && (bus.addr == BASE_ADDR + OFF_SEGCTRL);
    assign wr_irqstat = bus.mem_wr && (bus.addr == BASE_ADDR + OFF_IRQSTAT);

    for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_tmr
        periph_timer_ch #(.TIMER_W(TIMER_W)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .th_wr   (bus.mem_wr && (bus.addr == tmr_addr(BASE_ADDR, k, OFF_TH))),
            .tl_wr   (bus.mem_wr && (bus.addr == tmr_addr(BASE_ADDR, k, OFF_TL))),
            .tcon_wr (bus.mem_wr && (bus.addr == tmr_addr(BASE_ADDR, k, OFF_TCON))),
            .pend_clr(wr_irqstat && bus.wdata[k]),
            .wval    (bus.wdata[TIMER_W-1:0]),
            .th      (th[k]),
            .tl      (tl[k]),
            .en      (en[k]),
            .ie      (ie[k]),
            .pending (pending[k])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q   <= '0;
            sw_s1   <= '0;
            sw_s2   <= '0;
            segdata <= '0;
            scan_en <= 1'b0;
        end else begin
            if (wr_led)     led_q   <= bus.wdata[LED_W-1:0];
            if (wr_segdata) segdata <= bus.wdata & SEG_MASK;
            if (wr_segctrl) scan_en <= bus.wdata[0];
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
        end
    end

    // Scanner: an/seg are registered from the current index, so they trail it by one clock.
    logic [31:0] nib_sh;
    logic [7:0]  dp_sh;
    assign nib_sh = segdata >> {idx, 2'b00};
    assign dp_sh  = segdata[31:24] >> idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            idx   <= '0;
            an    <= '1;
            seg   <= 8'hFF;
        end else if (!scan_en) begin
            presc <= '0;
            idx   <= '0;
            an    <= '1;
            seg   <= 8'hFF;
        end else begin
            presc <= presc + SCAN_DIV_W'(1);
            if (&presc) idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            an  <= ~(DIG_ONE << idx);
            seg <= ~{dp_sh[0], HEX7[nib_sh[3:0]]};
        end
    end

`ifdef SWITCH_CHANGE_IRQ_EN
    logic [SW_W-1:0] sw_prev, sw_chg, sw_mask;
    logic wr_swchg, wr_swmask;
    assign wr_swchg  = bus.mem_wr && (bus.addr == BASE_ADDR + OFF_SWCHG);
    assign wr_swmask = bus.mem_wr && (bus.addr == BASE_ADDR + OFF_SWMASK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_prev <= '0;
            sw_chg  <= '0;
            sw_mask <= '0;
        end else begin
            sw_prev <= sw_s2;
            sw_chg  <= (sw_chg & ~(wr_swchg ? bus.wdata[SW_W-1:0] : '0)) | (sw_s2 ^ sw_prev);
            if (wr_swmask) sw_mask <= bus.wdata[SW_W-1:0];
        end
    end

    assign irq = (|timer_irq) | (|(sw_chg & sw_mask));
`else
    assign irq = |timer_irq;
`endif

    always_comb begin
        rd_c = '0;
        if (bus.mem_rd) begin
            if (bus.addr == BASE_ADDR + OFF_LED)     rd_c = 32'(led_q);
            if (bus.addr == BASE_ADDR + OFF_SWITCH)  rd_c = 32'(sw_s2);
            if (bus.addr == BASE_ADDR + OFF_SEGDATA) rd_c = segdata;
            if (bus.addr == BASE_ADDR + OFF_SEGCTRL) rd_c = 32'(scan_en);
            if (bus.addr == BASE_ADDR + OFF_IRQSTAT) rd_c = 32'(pending);
`ifdef SWITCH_CHANGE_IRQ_EN
            if (bus.addr == BASE_ADDR + OFF_SWCHG)   rd_c = 32'(sw_chg);
            if (bus.addr == BASE_ADDR + OFF_SWMASK)  rd_c = 32'(sw_mask);
`endif
            for (int k = 0; k < NUM_TIMERS; k++) begin
                if (bus.addr == tmr_addr(BASE_ADDR, k, OFF_TH))   rd_c = 32'(th[k]);
                if (bus.addr == tmr_addr(BASE_ADDR, k, OFF_TL))   rd_c = 32'(tl[k]);
                if (bus.addr == tmr_addr(BASE_ADDR, k, OFF_TCON)) rd_c = 32'({pending[k], ie[k], en[k]});
            end
        end
    end

    assign bus.rdata = rd_c;
    assign led       = led_q;
    assign timer_irq = pending & ie;

endmodule

// File: tb/tb_periph_timer_bank.sv
// Bench for periph_timer_bank: register reads, timer wrap/reload races, W1C, scanner, switches.
module tb_periph_timer_bank;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_LED = BASE + 32'h00, A_SW = BASE + 32'h04, A_SEGD = BASE + 32'h08;
    localparam logic [31:0] A_SEGC = BASE + 32'h0C, A_IRQS = BASE + 32'h10;
    localparam logic [31:0] A_CHG = BASE + 32'h14, A_MSK = BASE + 32'h18;
    localparam logic [31:0] A_TH0 = BASE + 32'h20, A_TL0 = BASE + 32'h24, A_TC0 = BASE + 32'h28;
    localparam logic [31:0] A_TH1 = BASE + 32'h30, A_TL1 = BASE + 32'h34, A_TC1 = BASE + 32'h38;
    localparam logic [6:0] SEG7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] led, sw, seg;
    logic [3:0] an;
    logic [1:0] timer_irq;
    logic       irq;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    periph_timer_bank_if bus();

    periph_timer_bank #(.SCAN_DIV_W(2)) dut (
        .clk(clk), .reset(reset), .bus(bus), .led(led), .sw(sw),
        .an(an), .seg(seg), .timer_irq(timer_irq), .irq(irq)
    );

    always #5 clk = ~clk;

    // Bus helpers: entered and left 1 time unit after a rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.wdata = d; bus.mem_wr = 1'b1;
        @(posedge clk); #1;
        bus.mem_wr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a; bus.mem_rd = 1'b1;
        @(negedge clk);
        d = bus.rdata;
        @(posedge clk); #1;
        bus.mem_rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] addrs[$];
        logic [31:0] got, e;
        addrs = '{A_LED, A_SW, A_SEGD, A_SEGC, A_IRQS, A_CHG, A_MSK, A_TH0, A_TL0, A_TC0, A_TH1, A_TL1, A_TC1};
        exp_q = '{0, 0, 0, 0, 0, 0, 0, 32'hFFFF_F800, 32'hFFFF_F800, 0, 32'hFFFF_F800, 32'hFFFF_F800, 0};
        foreach (addrs[i]) begin
            rd(addrs[i], got);
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin miscompares++; $display("FAIL reset_reg[%h]: got %h want %h", addrs[i], got, e); end
        end
        exp_q.push_back({16'h0, 4'hF, 2'b00, timer_irq === 2'b00, irq === 1'b0, 8'hFF});
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if ({16'h0, an, 2'b00, timer_irq === 2'b00, irq === 1'b0, seg} !== e) begin
            miscompares++; $display("FAIL reset_pins: an=%h seg=%h irq=%b timer_irq=%b", an, seg, irq, timer_irq);
        end
        vectors++;
        if (irq !== 1'b0 || led !== 8'h00) begin miscompares++; $display("FAIL reset_irq_led: irq=%b led=%h want 0/00", irq, led); end
        bus.addr = A_TH0; bus.mem_rd = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL rdata_idle: got %h want 0", bus.rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_timer_wrap();
        logic [31:0] e, got;
        wr(A_TH0, 32'hFFFF_FFF0);
        wr(A_TL0, 32'hFFFF_FFF0);
        wr(A_TC0, 32'h3);
        // Counting starts the edge after enable; the wrap edge is the 16th after the write edge.
        bus.addr = A_TL0; bus.mem_rd = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            exp_q.push_back(i < 16 ? 32'hFFFF_FFF0 + 32'(i) : 32'hFFFF_FFF0);
            exp_q.push_back(i >= 16 ? 32'h1 : 32'h0);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (bus.rdata !== e) begin miscompares++; $display("FAIL tl0_count[%0d]: got %h want %h", i, bus.rdata, e); end
            e = exp_q.pop_front();
            vectors++;
            if (32'(irq) !== e) begin miscompares++; $display("FAIL irq_rise[%0d]: got %b want %0d", i, irq, e); end
            @(posedge clk); #1;
        end
        bus.mem_rd = 1'b0;
        rd(A_TC0, got);
        vectors++;
        if (got !== 32'h7) begin miscompares++; $display("FAIL tcon0_pend: got %h want 7", got); end
        wr(A_IRQS, 32'h1);
        @(negedge clk);
        vectors++;
        if (irq !== 1'b0 || timer_irq !== 2'b00) begin miscompares++; $display("FAIL irq_w1c: irq=%b timer_irq=%b want 0/00", irq, timer_irq); end
        @(posedge clk); #1;
        wr(A_TC0, 32'h0);
    endtask

    task automatic test_w1c_collision();
        logic [31:0] got;
        wr(A_TH1, 32'hFFFF_FFF0);
        wr(A_TL1, 32'hFFFF_FFF0);
        wr(A_TC1, 32'h3);
        repeat (15) @(posedge clk);
        #1;
        wr(A_IRQS, 32'h2);
        rd(A_IRQS, got);
        vectors++;
        if (got !== 32'h2) begin miscompares++; $display("FAIL w1c_vs_set: got %h want 2", got); end
        vectors++;
        if (irq !== 1'b1 || timer_irq !== 2'b10) begin miscompares++; $display("FAIL w1c_vs_set_irq: irq=%b timer_irq=%b want 1/10", irq, timer_irq); end
        wr(A_TC1, 32'h0);
        wr(A_IRQS, 32'h2);
        rd(A_IRQS, got);
        vectors++;
        if (got !== 32'h0) begin miscompares++; $display("FAIL irqstat_clear: got %h want 0", got); end
    endtask

    task automatic test_no_irq_reload();
        logic [31:0] got;
        wr(A_TH0, 32'h1234_5678);
        wr(A_TL0, 32'hFFFF_FFFD);
        wr(A_TC0, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        exp_q = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0};
        rd(A_TL0, got);
        vectors++;
        if (got !== exp_q[0]) begin miscompares++; $display("FAIL tl_allones: got %h want %h", got, exp_q[0]); end
        void'(exp_q.pop_front());
        rd(A_TL0, got);
        vectors++;
        if (got !== exp_q[0]) begin miscompares++; $display("FAIL tl_reload: got %h want %h", got, exp_q[0]); end
        void'(exp_q.pop_front());
        rd(A_IRQS, got);
        vectors++;
        if (got !== exp_q[0] || irq !== 1'b0) begin miscompares++; $display("FAIL no_ie_pend: got %h irq=%b want 0/0", got, irq); end
        void'(exp_q.pop_front());
        // TL write on the reload edge wins.
        wr(A_TC0, 32'h0); wr(A_TL0, 32'hFFFF_FFFD); wr(A_TC0, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        wr(A_TL0, 32'h0000_ABCD);
        rd(A_TL0, got);
        vectors++;
        if (got !== 32'h0000_ABCD) begin miscompares++; $display("FAIL tl_write_wins: got %h want 0000abcd", got); end
        // TH write on the reload edge: reload takes the old TH.
        wr(A_TC0, 32'h0); wr(A_TL0, 32'hFFFF_FFFD); wr(A_TC0, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        wr(A_TH0, 32'h0000_0055);
        rd(A_TL0, got);
        vectors++;
        if (got !== 32'h1234_5678) begin miscompares++; $display("FAIL th_old_reload: got %h want 12345678", got); end
        rd(A_TH0, got);
        vectors++;
        if (got !== 32'h0000_0055) begin miscompares++; $display("FAIL th_write: got %h want 00000055", got); end
        wr(A_TC0, 32'h0);
    endtask

    task automatic test_scan();
        logic [31:0] e, got;
        logic [3:0]  nib;
        int d;
        wr(A_SEGD, 32'h0400_1234);
        wr(A_SEGC, 32'h1);
        for (int i = 0; i < 18; i++) begin
            if (i == 0) exp_q.push_back({20'h0, 4'hF, 8'hFF});
            else begin
                d = ((i - 1) / 4) % 4;
                nib = 4'(32'h1234 >> (4 * d));
                exp_q.push_back({20'h0, ~(4'b0001 << d), ~{(d == 2), SEG7[nib]}});
            end
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if ({20'h0, an, seg} !== e) begin miscompares++; $display("FAIL scan[%0d]: an=%h seg=%h want an=%h seg=%h", i, an, seg, e[11:8], e[7:0]); end
            @(posedge clk); #1;
        end
        wr(A_SEGC, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (an !== 4'hF || seg !== 8'hFF) begin miscompares++; $display("FAIL scan_off: an=%h seg=%h want F/FF", an, seg); end
        @(posedge clk); #1;
        rd(A_SEGD, got);
        vectors++;
        if (got !== 32'h0400_1234) begin miscompares++; $display("FAIL segdata_rb: got %h want 04001234", got); end
    endtask

    task automatic test_switch();
        logic [31:0] e, got;
        sw = 8'hA5;
        bus.addr = A_SW; bus.mem_rd = 1'b1;
        exp_q = '{32'h00, 32'h00, 32'hA5};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (bus.rdata !== e) begin miscompares++; $display("FAIL sw_sync[%0d]: got %h want %h", i, bus.rdata, e); end
            @(posedge clk); #1;
        end
        bus.mem_rd = 1'b0;
`ifdef SWITCH_CHANGE_IRQ_EN
        wr(A_CHG, 32'hFF);
        wr(A_MSK, 32'h01);
        rd(A_CHG, got);
        vectors++;
        if (got !== 32'h0 || irq !== 1'b0) begin miscompares++; $display("FAIL chg_cleared: got %h irq=%b want 0/0", got, irq); end
        sw = 8'hA4;
        exp_q = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (32'(irq) !== e) begin miscompares++; $display("FAIL sw_chg_irq[%0d]: got %b want %0d", i, irq, e); end
            @(posedge clk); #1;
        end
        rd(A_CHG, got);
        vectors++;
        if (got !== 32'h01) begin miscompares++; $display("FAIL chg_stat: got %h want 01", got); end
        wr(A_CHG, 32'h01);
        @(negedge clk);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL chg_w1c: irq=%b want 0", irq); end
        @(posedge clk); #1;
`else
        wr(A_MSK, 32'hFF);
        rd(A_MSK, got);
        vectors++;
        if (got !== 32'h0) begin miscompares++; $display("FAIL mask_unmapped: got %h want 0", got); end
        sw = 8'hA4;
        repeat (4) @(posedge clk);
        #1;
        rd(A_CHG, got);
        vectors++;
        if (got !== 32'h0 || irq !== 1'b0) begin miscompares++; $display("FAIL chg_unmapped: got %h irq=%b want 0/0", got, irq); end
`endif
    endtask

    task automatic test_unmapped();
        logic [31:0] addrs[$];
        logic [31:0] got;
        wr(A_LED, 32'hFFFF_FF5A);
        wr(BASE + 32'h1C, 32'hFFFF_FFFF);
        wr(32'h0000_0000, 32'h0000_00FF);
        wr(BASE + 32'h40, 32'h0000_0011);
        rd(A_LED, got);
        vectors++;
        if (got !== 32'h5A || led !== 8'h5A) begin miscompares++; $display("FAIL led_rw: got %h led=%h want 5a", got, led); end
        addrs = '{BASE + 32'h1C, BASE + 32'h2C, BASE + 32'h40, 32'h0000_0000, 32'h4000_1000};
        foreach (addrs[i]) begin
            rd(addrs[i], got);
            vectors++;
            if (got !== 32'h0) begin miscompares++; $display("FAIL unmapped[%h]: got %h want 0", addrs[i], got); end
        end
    endtask

    task automatic test_reset_mid();
        wr(A_TL0, 32'hFFFF_FFFE);
        wr(A_TC0, 32'h3);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL pre_reset_irq: irq=%b want 1", irq); end
        bus.addr = A_TL0; bus.mem_rd = 1'b1;
        reset = 1'b0;
        #1;
        vectors++;
        if (irq !== 1'b0 || bus.rdata !== 32'hFFFF_F800 || led !== 8'h00) begin
            miscompares++; $display("FAIL reset_mid: irq=%b tl=%h led=%h want 0/fffff800/00", irq, bus.rdata, led);
        end
        #2 reset = 1'b1;
        bus.mem_rd = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        sw = 8'h00;
        bus.addr = '0; bus.wdata = '0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
        #23 reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_timer_wrap();
        test_w1c_collision();
        test_no_irq_reload();
        test_scan();
        test_switch();
        test_unmapped();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
